// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter.
//   PAR_NONE/PAR_ODD/PAR_EVEN : values accepted by the PARITY parameter
//   state_t                   : transmit FSM state encoding
//   uart_div()                : clocks per bit for a clock/baud pair
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // Integer-truncated clocks per bit.
  function automatic int uart_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Write-side handshake of the UART transmitter.
//   din       : word to send
//   din_valid : din is valid this cycle
//   din_ready : transmitter can accept a word this cycle
// master = word producer, slave = transmitter.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] din;
  logic                 din_valid;
  logic                 din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO feeding the transmitter.
//   clk, rst     : clock, synchronous active-high flush
//   push, wdata  : write a word (ignored when full)
//   pop, rdata   : rdata is the head word; pop discards it (ignored when empty)
//   full, empty  : occupancy flags from the extra-MSB pointers
//   level        : registered word count
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers carry one wrap bit: equal = empty, same index with the wrap
  // bit flipped = full.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Buffered, parametrised UART transmitter (LSB first, configurable
// data width / parity / stop bits / FIFO depth / baud divisor).
//   clk, rst   : clock, synchronous active-high reset (aborts any frame)
//   wr         : din/din_valid/din_ready write handshake into the FIFO
//   fifo_level : words waiting, not counting the one being sent
//   tx_busy    : a frame is in progress
//   tx_p       : serial line, idles high
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_tx_param_if.slave                wr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_busy,
  output logic                          tx_p
);

  localparam int DIV = uart_div(CLK_FREQ, BAUD);
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_param: CLK_FREQ/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_par
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
  end

  state_t               state, nxt;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg, rdata;
  logic                 par, par_bit;
  logic                 full, empty, push, pop;
  logic                 bit_end, last_data, last_stop, tx_nxt;

  assign wr.din_ready = !rst && !full;
  assign push         = wr.din_valid && wr.din_ready;

  uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr.din),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign bit_end   = (cnt == CW'(DIV - 1));
  assign last_data = bit_end && (bit_cnt == 4'(DATA_BITS - 1));
  assign last_stop = bit_end && (bit_cnt == 4'(STOP_BITS - 1));
  // par holds the XOR of every data bit once the last one is on the line.
  assign par_bit   = (PARITY == PAR_EVEN) ? par : !par;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (!empty)   nxt = ST_START;
      ST_START:  if (bit_end)  nxt = ST_DATA;
      ST_DATA:   if (last_data) nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end)  nxt = ST_STOP;
      ST_STOP:   if (last_stop) nxt = empty ? ST_IDLE : ST_START;
      default:                 nxt = ST_IDLE;
    endcase
  end

  // Pop and next line level. At a frame boundary the line goes low exactly
  // when a word is popped, otherwise it stays at the idle level.
  always_comb begin
    pop    = 1'b0;
    tx_nxt = tx_p;
    case (state)
      ST_IDLE: begin
        pop    = !empty;
        tx_nxt = empty;
      end
      ST_START:  if (bit_end) tx_nxt = shreg[0];
      ST_DATA: begin
        if (last_data)    tx_nxt = (PARITY == PAR_NONE) ? 1'b1 : par_bit;
        else if (bit_end) tx_nxt = shreg[0];
      end
      ST_PARITY: if (bit_end) tx_nxt = 1'b1;
      ST_STOP: begin
        if (last_stop) begin
          pop    = !empty;
          tx_nxt = empty;
        end
      end
      default:   tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_p    <= 1'b1;
      tx_busy <= 1'b0;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
    end else begin
      tx_p    <= tx_nxt;
      tx_busy <= (nxt != ST_IDLE);
      if (pop) begin
        cnt     <= '0;
        bit_cnt <= '0;
        shreg   <= rdata;
        par     <= 1'b0;
      end else if (state != ST_IDLE) begin
        cnt <= bit_end ? '0 : cnt + 1'b1;
        if (bit_end) begin
          // A data bit leaves the shifter whenever it is put on the line.
          if (state == ST_START || (state == ST_DATA && !last_data)) begin
            shreg <= shreg >> 1;
            par   <= par ^ shreg[0];
          end
          bit_cnt <= ((state == ST_DATA && !last_data) || (state == ST_STOP && !last_stop))
                     ? bit_cnt + 1'b1 : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
module tb_uart_tx_param;

  localparam int DIV   = 10;
  localparam int FRAME = 100;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_param_if #(.DATA_BITS(8)) m_if ();
  uart_tx_param_if #(.DATA_BITS(7)) s7 ();
  uart_tx_param_if #(.DATA_BITS(8)) so ();
  uart_tx_param_if #(.DATA_BITS(8)) se ();

  logic [4:0] m_level;
  logic       m_busy, m_tx;
  logic [1:0] s7_level, so_level, se_level;
  logic       s7_busy, s7_tx, so_busy, so_tx, se_busy, se_tx;

  uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .wr(m_if), .fifo_level(m_level), .tx_busy(m_busy), .tx_p(m_tx));
  uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(2),
                  .STOP_BITS(2), .FIFO_DEPTH(2)) dut_7e2 (
    .clk(clk), .rst(rst), .wr(s7), .fifo_level(s7_level), .tx_busy(s7_busy), .tx_p(s7_tx));
  uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1),
                  .STOP_BITS(1), .FIFO_DEPTH(2)) dut_8o1 (
    .clk(clk), .rst(rst), .wr(so), .fifo_level(so_level), .tx_busy(so_busy), .tx_p(so_tx));
  uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .FIFO_DEPTH(2)) dut_8e1 (
    .clk(clk), .rst(rst), .wr(se), .fifo_level(se_level), .tx_busy(se_busy), .tx_p(se_tx));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Running busy/full cycle counts; tests take differences over a window.
  int m_bt = 0, s7_bt = 0, so_bt = 0, se_bt = 0, full_cyc = 0;
  always @(negedge clk) begin
    if (m_busy === 1'b1)  m_bt  <= m_bt + 1;
    if (s7_busy === 1'b1) s7_bt <= s7_bt + 1;
    if (so_busy === 1'b1) so_bt <= so_bt + 1;
    if (se_busy === 1'b1) se_bt <= se_bt + 1;
    if (m_level === 5'd16) full_cyc <= full_cyc + 1;
  end

  // ---------------- reference model of the 8N1 instance ----------------
  // Words queue up; a frame is a 100-cycle window whose line level is read
  // off the 10-bit frame {stop, data[7:0], start} at bit (cycle / DIV).
  function automatic logic exp_line(input logic [7:0] w, input int cyc);
    int b;
    b = cyc / DIV;
    if (b == 0) return 1'b0;
    if (b <= 8) return w[b-1];
    return 1'b1;
  endfunction

  logic [7:0] mq[$];
  logic       mdl_on = 1'b0;
  logic [7:0] mdl_w = 8'h00;
  int         mdl_c = 0;
  logic       p_rst, p_val;
  logic [7:0] p_din;
  bit         started = 1'b0;

  // Inputs change 2ns after a rising edge, so the values seen on a falling
  // edge are the ones the next rising edge samples.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        if (p_rst) begin
          mq.delete();
          mdl_on = 1'b0;
          mdl_c  = 0;
        end else begin
          bit can_push, at_end;
          can_push = p_val && (mq.size() < DEPTH);
          at_end   = mdl_on && (mdl_c == FRAME - 1);
          if ((!mdl_on || at_end) && mq.size() > 0) begin
            mdl_w  = mq.pop_front();
            mdl_on = 1'b1;
            mdl_c  = 0;
          end else if (at_end) begin
            mdl_on = 1'b0;
            mdl_c  = 0;
          end else if (mdl_on) begin
            mdl_c++;
          end
          if (can_push) mq.push_back(p_din);
        end
        chk("line", m_tx, mdl_on ? exp_line(mdl_w, mdl_c) : 1'b1);
        chk("busy", m_busy, mdl_on);
        chk("level", m_level, mq.size());
        chk("ready", m_if.din_ready, !rst && (mq.size() < DEPTH));
      end
      p_rst   = rst;
      p_val   = m_if.din_valid;
      p_din   = m_if.din;
      started = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_busy === 1'b0 && m_level === 5'd0) && n < budget);
    chk(name, (m_busy === 1'b0 && m_level === 5'd0), 1);
  endtask

  // n random words with din_valid held high; din advances on each accept.
  task automatic burst(input int n);
    int i, guard;
    bit acc;
    i = 0;
    guard = 0;
    @(posedge clk); #2;
    m_if.din_valid = 1'b1;
    m_if.din = 8'($urandom);
    while (i < n && guard < 5000) begin
      @(negedge clk);
      acc = m_if.din_ready;
      @(posedge clk); #2;
      guard++;
      if (acc) begin
        i++;
        m_if.din = 8'($urandom);
      end
    end
    m_if.din_valid = 1'b0;
    chk("burst_accepted", i, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish by 2ms");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [10:0] g7, go, ge, x7, xo, xe;
    logic [9:0]  g8, x8;
    int b0, b1, b2, f0, zeros, busy_seen;

    rst = 1'b1;
    m_if.din = '0; m_if.din_valid = 1'b0;
    s7.din = '0;   s7.din_valid = 1'b0;
    so.din = '0;   so.din_valid = 1'b0;
    se.din = '0;   se.din_valid = 1'b0;
    g7 = '0; go = '0; ge = '0; g8 = '0;

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", m_if.din_ready, 0);
    chk("rst_tx", m_tx, 1);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", m_if.din_ready, 1);
    chk("rel_level", m_level, 0);
    chk("rel_tx", m_tx, 1);
    chk("rel_busy", m_busy, 0);

    // 7E2 0x35, 8O1 0x00, 8E1 0xFF, sampled mid-bit.
    x7 = 11'b11001101010;
    xo = 11'b11000000000;
    xe = 11'b10111111110;
    @(posedge clk); #2;
    s7.din = 7'h35; s7.din_valid = 1'b1;
    so.din = 8'h00; so.din_valid = 1'b1;
    se.din = 8'hFF; se.din_valid = 1'b1;
    @(posedge clk); #2;
    s7.din_valid = 1'b0; so.din_valid = 1'b0; se.din_valid = 1'b0;
    b0 = s7_bt; b1 = so_bt; b2 = se_bt;
    @(negedge clk);
    for (int c = 0; c < 130; c++) begin
      @(negedge clk);
      if (c % DIV == 5 && c / DIV < 11) begin
        g7[c/DIV] = s7_tx;
        go[c/DIV] = so_tx;
        ge[c/DIV] = se_tx;
      end
    end
    @(posedge clk); #2;
    chk("7e2_frame", g7, x7);
    chk("8o1_frame", go, xo);
    chk("8e1_frame", ge, xe);
    chk("7e2_busy_cycles", s7_bt - b0, 110);
    chk("8o1_busy_cycles", so_bt - b1, 110);
    chk("8e1_busy_cycles", se_bt - b2, 110);

    // 8N1 0xA5.
    x8 = 10'b1101001010;
    m_if.din = 8'hA5; m_if.din_valid = 1'b1;
    @(posedge clk); #2;
    m_if.din_valid = 1'b0;
    b0 = m_bt;
    @(negedge clk);
    chk("a5_level_after_write", m_level, 1);
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (c == 0) chk("a5_start_level", m_level, 0);
      if (c % DIV == 5 && c / DIV < 10) g8[c/DIV] = m_tx;
    end
    @(posedge clk); #2;
    chk("a5_frame", g8, x8);
    chk("a5_busy_cycles", m_bt - b0, 100);

    // Push lands on the same edge as the pop at level 1.
    m_if.din = 8'h3C; m_if.din_valid = 1'b1;
    @(posedge clk); #2;
    m_if.din = 8'hC3;
    @(negedge clk);
    chk("simul_pre_level", m_level, 1);
    @(posedge clk); #2;
    m_if.din_valid = 1'b0;
    @(negedge clk);
    chk("simul_level", m_level, 1);
    chk("simul_busy", m_busy, 1);
    wait_idle(400, "simul_drain");

    // 20 back-to-back words through a 16-deep FIFO.
    @(posedge clk); #2;
    b0 = m_bt; f0 = full_cyc;
    burst(20);
    wait_idle(3000, "burst_drain");
    @(posedge clk); #2;
    chk("burst_busy_cycles", m_bt - b0, 2000);
    chk("burst_reached_full", (full_cyc - f0) > 0, 1);

    // Random traffic, sparse enough to both idle and fill the FIFO.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #2;
      m_if.din_valid = ($urandom_range(0, 39) == 0);
      m_if.din = 8'($urandom);
    end
    @(posedge clk); #2;
    m_if.din_valid = 1'b0;
    wait_idle(4000, "rand_drain");

    // Reset at cycle 45 of a frame with 3 words queued behind it.
    burst(4);
    repeat (43) begin @(posedge clk); #2; end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_pre_level", m_level, 3);
    chk("mid_pre_busy", m_busy, 1);
    @(negedge clk);
    chk("mid_rst_tx", m_tx, 1);
    chk("mid_rst_busy", m_busy, 0);
    chk("mid_rst_level", m_level, 0);
    chk("mid_rst_ready", m_if.din_ready, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rel_ready", m_if.din_ready, 1);
    zeros = 0; busy_seen = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (m_tx !== 1'b1) zeros++;
      if (m_busy !== 1'b0) busy_seen++;
    end
    chk("mid_no_start_bits", zeros, 0);
    chk("mid_no_busy", busy_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised, buffered UART transmitter; successor to the fixed 8N1 transmitter. It accepts words over a valid/ready handshake into an internal FIFO and serialises them LSB-first onto `tx_p`. Data width, parity mode, stop-bit count, FIFO depth and baud divisor are all configurable. It sits between any byte/word producer (debug console, SD-card log path) and the board UART pin, and it removes the need for the producer to poll `tx_busy`.

## Interface
- `CLK_FREQ`, 50_000_000: input clock frequency in Hz.
- `BAUD`, 115200: line rate. `DIV = CLK_FREQ/BAUD`, integer-truncated. Elaboration fails if `DIV < 2`.
- `DATA_BITS`, 8: payload width, legal range 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even. Any other value fails elaboration.
- `STOP_BITS`, 1: legal values 1 or 2.
- `FIFO_DEPTH`, 16: number of words. Must be a power of two, ≥2.
- `clk  in  1`: the single clock.
- `rst  in  1`: synchronous, active-high reset.
- `din  in  DATA_BITS`: word to send.
- `din_valid  in  1`: `din` is valid this cycle.
- `din_ready  out  1`: equals `!full`. Forced to 0 while `rst` is high.
- `fifo_level  out  $clog2(FIFO_DEPTH)+1`: number of words currently stored, excluding the word in flight.
- `tx_busy  out  1`: high whenever the FSM is not IDLE.
- `tx_p  out  1`: serial line. Idle level is 1.

## Operation
- **Accept:** a write is accepted on a rising edge when `din_valid && din_ready`. `din` is captured into the FIFO.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty. On that edge the head word is popped into the shift register, `tx_p` is driven to 0, and the baud counter is cleared.
  - START → DATA after `DIV` cycles.
  - DATA shifts out `DATA_BITS` bits, LSB first, each held for `DIV` cycles.
  - DATA → PARITY if `PARITY != 0`, otherwise DATA → STOP.
  - PARITY lasts `DIV` cycles.
    - Even parity: the parity bit is the XOR of the data bits.
    - Odd parity: the parity bit is the inverse of that XOR.
  - STOP holds `tx_p = 1` for `STOP_BITS*DIV` cycles.
- **End of STOP:**
  - If the FIFO is non-empty, go directly to START (pop, `tx_p` = 0) on the same edge, so there are zero idle cycles between frames.
  - If the FIFO is empty, go to IDLE.
- **Baud counter:** runs only while not IDLE and restarts at every frame start. Every bit, including the start bit, is exactly `DIV` cycles long. The counter is sized `$clog2(DIV)` bits and wraps `DIV-1 → 0`.
- **Frame length:** `(1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * DIV` cycles.
- **Simultaneous push and pop:** `fifo_level` is unchanged. When the FIFO is full, `din_ready` is 0, so no push can occur. A pop on that edge raises `din_ready` on the next cycle.
- **Empty FIFO:** no pop is issued and `tx_p` stays 1.
- **Reset:** takes effect on the edge where `rst` is sampled high. It applies mid-frame too; the aborted frame is truncated and not retried.
  - `tx_p` = 1
  - state = IDLE, `tx_busy` = 0
  - FIFO flushed, `fifo_level` = 0
  - shift register and counter = 0

## Timing
- **Reset values:** `tx_p` = 1, `tx_busy` = 0, `fifo_level` = 0, `din_ready` = 0 while `rst` is high and 1 on the first cycle after release.
- **Latency:** a write accepted at edge k into an empty FIFO with the FSM idle gives:
  - `fifo_level` = 1 after edge k.
  - Pop at edge k+1: `tx_p` = 0, `tx_busy` = 1, `fifo_level` = 0 after that edge.
- **Bit timing:** bit i occupies cycles `[k+1+(1+i)*DIV, k+1+(2+i)*DIV)`.
- **End of busy:** `tx_busy` falls on the edge that ends the last stop bit, and only if the FIFO is empty at that edge.
- **Registered outputs:** `tx_p`, `tx_busy` and `fifo_level` are registered. `din_ready` is a combinational function of registered full/rst only.

## Structure
- **Package `uart_pkg`:**
  - parity encoding constants `PAR_NONE` / `PAR_ODD` / `PAR_EVEN`
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP)
  - `uart_div(clk_freq, baud)` function
- **Sub-module `uart_tx_fifo`:** synchronous FIFO parameterised by `WIDTH` and `DEPTH`. It provides push/pop/full/empty/level, uses an extra-MSB pointer scheme, and has a synchronous reset flush.
- **Top level:** holds the FSM, the baud counter, the shift register and the parity accumulator.

## Test plan
Bench setup: `CLK_FREQ` = 1_000_000, `BAUD` = 100_000, giving `DIV` = 10.

- **8N1, `din` = 0xA5:** `tx_p` sequence 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles. Frame = 100 cycles. `tx_busy` is high for exactly 100 cycles.
- **7E2, `din` = 0x35:** data bits 1,0,1,0,1,1,0, then parity 0, then two stop bits. Frame = 110 cycles.
- **8O1, `din` = 0x00:** parity bit = 1. **8E1, `din` = 0xFF:** parity bit = 0.
- **Burst of 20 back-to-back writes (depth 16):** `din_ready` drops when `fifo_level` = 16 and recovers one cycle after each pop. All 20 words arrive in order with no gap: stop bit of word n is followed by start bit of word n+1 on the next cycle. Total time = 2000 cycles.
- **Simultaneous push and pop:** push a new word on the edge where the FSM pops at `fifo_level` = 1. `fifo_level` stays 1.
- **Reset mid-frame:** assert `rst` at cycle 45 of a frame with 3 words queued. After that edge: `tx_p` = 1, `tx_busy` = 0, `fifo_level` = 0. No further start bit appears within 500 cycles.
